// File: rtl/intc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// intc_pkg : shared types and register-map offsets for prio_intr_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
package intc_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  // Control register word indices, relative to the end of the PRIO array.
  localparam int unsigned ENABLE_OFS = 0;
  localparam int unsigned MODE_OFS   = 1;
  localparam int unsigned PEND_OFS   = 2;
  localparam int unsigned THR_OFS    = 3;
  localparam int unsigned STAT_OFS   = 4;

  function automatic int unsigned reg_idx(input int unsigned num_src, input int unsigned ofs);
    return num_src + ofs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intc_prio_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// intc_prio_arb : combinational highest-priority search, lowest index wins ties
// Rev 1.0
// ----------------------------------------------------------------------------
module intc_prio_arb
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int PRI_W   = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]            eligible,
  input  logic [NUM_SRC-1:0][PRI_W-1:0] prio,
  output logic [ID_W-1:0]               win_id,
  output logic                          found
);

  logic [PRI_W-1:0] best;

  // Strictly-greater replacement keeps the earliest index on equal priority.
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    best   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!found || (prio[i] > best))) begin
        found  = 1'b1;
        best   = prio[i];
        win_id = ID_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prio_intr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prio_intr_ctrl : prioritised interrupt controller with APB register file
// Rev 1.0
// ----------------------------------------------------------------------------
module prio_intr_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int PRI_W   = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_SRC),
  parameter int ADDR_W  = $clog2(NUM_SRC + 5)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic              irq_valid,
  output logic [ID_W-1:0]   irq_id,
  input  logic              irq_ack
);

  localparam int unsigned PRIO_END   = NUM_SRC;
  localparam int unsigned ENABLE_IDX = reg_idx(NUM_SRC, ENABLE_OFS);
  localparam int unsigned MODE_IDX   = reg_idx(NUM_SRC, MODE_OFS);
  localparam int unsigned PEND_IDX   = reg_idx(NUM_SRC, PEND_OFS);
  localparam int unsigned THR_IDX    = reg_idx(NUM_SRC, THR_OFS);
  localparam int unsigned STAT_IDX   = reg_idx(NUM_SRC, STAT_OFS);

  logic [NUM_SRC-1:0][PRI_W-1:0] prio_q;
  logic [NUM_SRC-1:0]            enable_q;
  logic [NUM_SRC-1:0]            mode_q;
  logic [NUM_SRC-1:0]            pending_q;
  logic [NUM_SRC-1:0]            src_d;
  logic [PRI_W-1:0]              thr_q;
  state_t                        state;

  logic                          access;
  logic [31:0]                   idx;
  logic                          bus_err;
  logic                          wr_en;
  logic [DATA_W-1:0]             rd_mux;
  logic [NUM_SRC-1:0]            edge_set;
  logic [NUM_SRC-1:0]            w1c;
  logic [NUM_SRC-1:0]            ack_clr;
  logic [NUM_SRC-1:0]            pending_nxt;
  logic [NUM_SRC-1:0]            eligible;
  logic [ID_W-1:0]               win_id;
  logic                          win_found;
  logic                          unused_wdata;

  assign unused_wdata = ^pwdata;

  assign access  = psel & penable;
  assign idx     = 32'(paddr);
  assign bus_err = (idx > STAT_IDX) | (pwrite & (idx == STAT_IDX));
  assign wr_en   = access & pwrite & ~bus_err;
  assign pready  = rstn & access;
  assign pslverr = rstn & access & bus_err;

  always_comb begin
    rd_mux = '0;
    if (idx < PRIO_END) begin
      rd_mux[PRI_W-1:0] = prio_q[paddr[ID_W-1:0]];
    end else if (idx == ENABLE_IDX) begin
      rd_mux[NUM_SRC-1:0] = enable_q;
    end else if (idx == MODE_IDX) begin
      rd_mux[NUM_SRC-1:0] = mode_q;
    end else if (idx == PEND_IDX) begin
      rd_mux[NUM_SRC-1:0] = pending_q;
    end else if (idx == THR_IDX) begin
      rd_mux[PRI_W-1:0] = thr_q;
    end else if (idx == STAT_IDX) begin
      rd_mux[ID_W:0] = {irq_valid, irq_id};
    end
  end

  // Edge sources latch until cleared; a fresh edge beats a same-cycle clear.
  // Level sources simply track the sampled line.
  always_comb begin
    edge_set    = irq_src & ~src_d & mode_q;
    w1c         = (wr_en && (idx == PEND_IDX)) ? (pwdata[NUM_SRC-1:0] & mode_q) : '0;
    ack_clr     = (state == WAIT_ACK && irq_ack)
                  ? (({{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id) & mode_q) : '0;
    pending_nxt = (~mode_q & irq_src)
                | (mode_q & (edge_set | (pending_q & ~(w1c | ack_clr))));
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_elig
    assign eligible[gi] = pending_q[gi] & enable_q[gi] & (prio_q[gi] > thr_q);
  end

  intc_prio_arb #(
    .NUM_SRC (NUM_SRC),
    .PRI_W   (PRI_W),
    .ID_W    (ID_W)
  ) u_arb (
    .eligible (eligible),
    .prio     (prio_q),
    .win_id   (win_id),
    .found    (win_found)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio_q    <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      thr_q     <= '0;
      pending_q <= '0;
      src_d     <= '0;
      prdata    <= '0;
    end else begin
      src_d     <= irq_src;
      pending_q <= pending_nxt;
      if (wr_en) begin
        if (idx < PRIO_END) begin
          prio_q[paddr[ID_W-1:0]] <= pwdata[PRI_W-1:0];
        end else if (idx == ENABLE_IDX) begin
          enable_q <= pwdata[NUM_SRC-1:0];
        end else if (idx == MODE_IDX) begin
          mode_q <= pwdata[NUM_SRC-1:0];
        end else if (idx == THR_IDX) begin
          thr_q <= pwdata[PRI_W-1:0];
        end
      end
      if (access) begin
        if (bus_err) begin
          prdata <= '0;
        end else if (!pwrite) begin
          prdata <= rd_mux;
        end
      end
    end
  end

  // Presented interrupt is frozen until acknowledged; no preemption.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            irq_id    <= win_id;
            irq_valid <= 1'b1;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prio_intr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_prio_intr_ctrl : directed and randomised bench with a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_prio_intr_ctrl;

  localparam int NS = 16;
  localparam int PW = 4;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int AW = 5;
  localparam int ENA = 16;
  localparam int MOD = 17;
  localparam int PND = 18;
  localparam int THR = 19;
  localparam int STA = 20;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic [NS-1:0] irq_src = '0;
  logic          irq_valid;
  logic [IW-1:0] irq_id;
  logic          irq_ack = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [PW-1:0] m_prio [NS];
  logic [NS-1:0] m_en, m_mode, m_pend, m_srcd;
  logic [PW-1:0] m_thr;
  logic          m_valid;
  int            m_id;
  logic [DW-1:0] m_prdata;

  prio_intr_ctrl #(
    .NUM_SRC (NS),
    .PRI_W   (PW),
    .DATA_W  (DW),
    .ID_W    (IW),
    .ADDR_W  (AW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .irq_src   (irq_src),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Highest priority level first, then lowest index within that level.
  function automatic int winner();
    for (int p = (1 << PW) - 1; p > int'(m_thr); p--)
      for (int i = 0; i < NS; i++)
        if (m_pend[i] && m_en[i] && int'(m_prio[i]) == p) return i;
    return -1;
  endfunction

  function automatic logic [31:0] read_reg(input logic [31:0] idx);
    if (idx < NS) return 32'(m_prio[idx]);
    case (idx)
      ENA:     return 32'(m_en);
      MOD:     return 32'(m_mode);
      PND:     return 32'(m_pend);
      THR:     return 32'(m_thr);
      STA:     return 32'({m_valid, 4'(m_id)});
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven,
  // then advance the DUT and compare the interrupt outputs.
  task automatic tick();
    logic [NS-1:0] np, w1c;
    logic [31:0]   idx;
    logic          acc, err;
    int            w;
    if (!rstn) begin
      for (int i = 0; i < NS; i++) m_prio[i] = '0;
      m_en = '0; m_mode = '0; m_pend = '0; m_srcd = '0; m_thr = '0;
      m_valid = 1'b0; m_id = 0; m_prdata = '0;
    end else begin
      w   = winner();
      acc = psel && penable;
      idx = 32'(paddr);
      err = (idx > STA) || (pwrite && idx == STA);
      w1c = (acc && pwrite && !err && idx == PND) ? pwdata[NS-1:0] : '0;
      for (int i = 0; i < NS; i++) begin
        if (m_mode[i])
          np[i] = (irq_src[i] && !m_srcd[i]) ||
                  (m_pend[i] && !w1c[i] && !(m_valid && irq_ack && m_id == i));
        else
          np[i] = irq_src[i];
      end
      if (acc) begin
        if (err) m_prdata = '0;
        else if (!pwrite) m_prdata = read_reg(idx);
        else if (idx < NS) m_prio[idx] = pwdata[PW-1:0];
        else if (idx == ENA) m_en = pwdata[NS-1:0];
        else if (idx == MOD) m_mode = pwdata[NS-1:0];
        else if (idx == THR) m_thr = pwdata[PW-1:0];
      end
      if (m_valid) begin
        if (irq_ack) m_valid = 1'b0;
      end else if (w >= 0) begin
        m_valid = 1'b1;
        m_id = w;
      end
      m_pend = np;
      m_srcd = irq_src;
    end
    @(posedge clk);
    #1;
    chk("irq_valid", 32'(irq_valid), 32'(m_valid));
    if (m_valid) chk("irq_id", 32'(irq_id), 32'(m_id));
  endtask

  task automatic apb(input logic wr, input int addr, input logic [31:0] data);
    logic [31:0] a;
    logic        exp_err;
    a = 32'(addr);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a[AW-1:0]; pwdata = data;
    #1;
    chk("pready_setup", 32'(pready), 32'd0);
    tick();
    penable = 1'b1;
    exp_err = (addr > STA) || (wr && addr == STA);
    #1;
    chk("pready", 32'(pready), 32'd1);
    chk("pslverr", 32'(pslverr), 32'(exp_err));
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("prdata", prdata, m_prdata);
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    apb(1'b1, addr, data);
  endtask

  task automatic rd(input int addr);
    apb(1'b0, addr, 32'd0);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    // Reset state and full register sweep
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("reset_valid", 32'(irq_valid), 32'd0);
    for (int a = 0; a <= STA; a++) begin
      rd(a);
      chk("reset_reg", prdata, 32'd0);
    end
    rd(STA + 1);
    chk("bad_idx_prdata", prdata, 32'd0);
    wr(STA, 32'hFFFF_FFFF);
    chk("stat_wr_prdata", prdata, 32'd0);

    // Two simultaneous edges, higher priority first
    wr(3, 5);
    wr(7, 9);
    wr(ENA, 32'h0088);
    wr(MOD, 32'h0088);
    irq_src = 16'h0088;
    tick();
    irq_src = '0;
    tick();
    chk("t2_valid", 32'(irq_valid), 32'd1);
    chk("t2_id", 32'(irq_id), 32'd7);
    ack();
    chk("t2_ackdrop", 32'(irq_valid), 32'd0);
    rd(PND);
    chk("t2_pend", prdata, 32'h0008);
    chk("t2_next_id", 32'(irq_id), 32'd3);
    ack();

    // Equal priorities: lowest index wins; threshold masks both
    wr(2, 4);
    wr(5, 4);
    wr(MOD, 32'h00AC);
    wr(ENA, 32'h00AC);
    irq_src = 16'h0024;
    tick();
    irq_src = '0;
    tick();
    chk("tie_id", 32'(irq_id), 32'd2);
    ack();
    tick();
    chk("tie_second", 32'(irq_id), 32'd5);
    ack();
    wr(THR, 4);
    irq_src = 16'h0024;
    tick();
    irq_src = '0;
    repeat (4) tick();
    chk("thr_block", 32'(irq_valid), 32'd0);
    rd(PND);
    chk("thr_pend", prdata, 32'h0024);
    wr(PND, 32'h0024);
    rd(PND);
    chk("w1c_clear", prdata, 32'd0);
    wr(THR, 0);

    // Level source held across ack is re-presented
    wr(1, 2);
    wr(ENA, 32'h00AE);
    irq_src[1] = 1'b1;
    tick();
    tick();
    chk("lvl_id", 32'(irq_id), 32'd1);
    ack();
    chk("lvl_ackdrop", 32'(irq_valid), 32'd0);
    tick();
    chk("lvl_again", 32'(irq_valid), 32'd1);
    irq_ack = 1'b1;
    irq_src[1] = 1'b0;
    tick();
    irq_ack = 1'b0;
    tick();
    chk("lvl_gone", 32'(irq_valid), 32'd0);
    rd(PND);
    chk("lvl_pend", prdata & 32'h2, 32'd0);

    // W1C colliding with a new edge; enable cleared while presented
    psel = 1'b1; pwrite = 1'b1; paddr = AW'(PND); pwdata = 32'h8; penable = 1'b0;
    tick();
    penable = 1'b1;
    irq_src[3] = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    irq_src[3] = 1'b0;
    tick();
    chk("w1c_race_id", 32'(irq_id), 32'd3);
    rd(PND);
    chk("w1c_race_pend", prdata & 32'h8, 32'h8);
    wr(ENA, 0);
    chk("hold_valid", 32'(irq_valid), 32'd1);
    chk("hold_id", 32'(irq_id), 32'd3);
    ack();
    wr(ENA, 32'h00AE);

    // Reset while presenting
    irq_src[7] = 1'b1;
    tick();
    irq_src[7] = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(irq_valid), 32'd1);
    rstn = 1'b0;
    tick();
    chk("rst_drop", 32'(irq_valid), 32'd0);
    rstn = 1'b1;
    tick();
    rd(PND);
    chk("rst_pend", prdata, 32'd0);
    rd(ENA);
    chk("rst_enable", prdata, 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < NS; i++) wr(i, $urandom_range(0, 15));
    wr(ENA, $urandom);
    wr(MOD, $urandom);
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      irq_src = irq_src ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      irq_ack = ($urandom_range(0, 2) == 0);
      if (r < 3) wr($urandom_range(0, 22), $urandom);
      else if (r < 6) rd($urandom_range(0, 22));
      else tick();
    end
    irq_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
